// File: rtl/holy_clint_mh_if.sv
// AXI-Lite bus bundle used by the HOLY CORE peripherals.
// The slave modport is the view a register block sees; the master modport is the view a bus driver sees.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/holy_clint_mh.sv
// Multi-hart CLINT: shared prescaled 64-bit mtime, per-hart mtimecmp/msip, AXI-Lite slave.
// One transaction is in flight at a time; reads win over writes when both arrive together.
module holy_clint_mh #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          NUM_HARTS = 1,
  parameter int          TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_lite_if.slave            s_axi_lite,
  output logic [NUM_HARTS-1:0] timer_irq,
  output logic [NUM_HARTS-1:0] soft_irq
);

  localparam logic [15:0] TICK_LAST   = 16'(TICK_DIV - 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RDATA,
    ST_WDATA,
    ST_WRESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic        tick;

  logic        aligned;
  logic        word_hi;
  logic        msip_hit;
  logic        cmp_hit;
  logic        mtime_hit;
  logic [3:0]  msip_idx;
  logic [3:0]  cmp_idx;
  logic        wr_fire;

  logic [63:0]          mtimecmp_vec [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_vec;

  logic [31:0] rdata_mux;
  logic [1:0]  rresp_mux;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Address decode works on the latched offset, so it is shared by the read and write paths.
  always_comb begin
    aligned   = (addr_q[1:0] == 2'b00);
    word_hi   = addr_q[2];
    msip_idx  = addr_q[5:2];
    cmp_idx   = addr_q[6:3];
    msip_hit  = aligned && (addr_q[31:14] == 18'h0) && (addr_q[13:2] < 12'(NUM_HARTS));
    cmp_hit   = aligned && (addr_q[31:14] == 18'h1) && (addr_q[13:3] < 11'(NUM_HARTS));
    mtime_hit = aligned && (addr_q[31:3] == 29'h17FF);
  end

  assign wr_fire = (state_q == ST_WDATA) && s_axi_lite.wvalid;

  // Unwritten mtime bytes follow the incremented value so a tick is never lost on a partial write.
  always_comb begin
    tick    = (presc_q == TICK_LAST);
    presc_d = tick ? 16'h0 : presc_q + 16'h1;
    mtime_d = mtime_q + 64'(tick);
    if (wr_fire && mtime_hit) begin
      if (word_hi) begin
        mtime_d[63:32] = merge_bytes(mtime_d[63:32], s_axi_lite.wdata, s_axi_lite.wstrb);
      end else begin
        mtime_d[31:0]  = merge_bytes(mtime_d[31:0], s_axi_lite.wdata, s_axi_lite.wstrb);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (s_axi_lite.arvalid) begin
          addr_d  = s_axi_lite.araddr - BASE_ADDR;
          state_d = ST_RDATA;
        end else if (s_axi_lite.awvalid) begin
          addr_d  = s_axi_lite.awaddr - BASE_ADDR;
          state_d = ST_WDATA;
        end
      end
      ST_RDATA: begin
        if (s_axi_lite.rready) state_d = ST_IDLE;
      end
      ST_WDATA: begin
        if (s_axi_lite.wvalid) begin
          err_d   = !(msip_hit || cmp_hit || mtime_hit);
          state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (s_axi_lite.bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0;
      err_q   <= 1'b0;
      presc_q <= 16'h0;
      mtime_q <= 64'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
    logic [63:0] cmp_q, cmp_d;
    logic        msip_q, msip_d;
    logic        sel_msip;
    logic        sel_cmp;

    always_comb begin
      sel_msip = wr_fire && msip_hit && (msip_idx == 4'(gi));
      sel_cmp  = wr_fire && cmp_hit && (cmp_idx == 4'(gi));
      cmp_d    = cmp_q;
      msip_d   = msip_q;
      if (sel_msip && s_axi_lite.wstrb[0]) msip_d = s_axi_lite.wdata[0];
      if (sel_cmp) begin
        if (word_hi) begin
          cmp_d[63:32] = merge_bytes(cmp_q[63:32], s_axi_lite.wdata, s_axi_lite.wstrb);
        end else begin
          cmp_d[31:0]  = merge_bytes(cmp_q[31:0], s_axi_lite.wdata, s_axi_lite.wstrb);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cmp_q  <= '1;
        msip_q <= 1'b0;
      end else begin
        cmp_q  <= cmp_d;
        msip_q <= msip_d;
      end
    end

    assign mtimecmp_vec[gi] = cmp_q;
    assign msip_vec[gi]     = msip_q;
    assign timer_irq[gi]    = (mtime_q >= cmp_q);
    assign soft_irq[gi]     = msip_q;
  end

  // mtime is read live, so a stalled read of it may advance; software uses hi/lo/hi.
  always_comb begin
    rdata_mux = 32'hFFFF_FFFF;
    rresp_mux = RESP_SLVERR;
    if (msip_hit) begin
      rresp_mux = RESP_OKAY;
      rdata_mux = 32'h0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (msip_idx == 4'(h)) rdata_mux = {31'h0, msip_vec[h]};
      end
    end else if (cmp_hit) begin
      rresp_mux = RESP_OKAY;
      rdata_mux = 32'h0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (cmp_idx == 4'(h)) rdata_mux = word_hi ? mtimecmp_vec[h][63:32] : mtimecmp_vec[h][31:0];
      end
    end else if (mtime_hit) begin
      rresp_mux = RESP_OKAY;
      rdata_mux = word_hi ? mtime_q[63:32] : mtime_q[31:0];
    end
  end

  assign s_axi_lite.arready = (state_q == ST_IDLE);
  assign s_axi_lite.awready = (state_q == ST_IDLE) && !s_axi_lite.arvalid;
  assign s_axi_lite.wready  = (state_q == ST_WDATA);
  assign s_axi_lite.rvalid  = (state_q == ST_RDATA);
  assign s_axi_lite.rdata   = rdata_mux;
  assign s_axi_lite.rresp   = rresp_mux;
  assign s_axi_lite.bvalid  = (state_q == ST_WRESP);
  assign s_axi_lite.bresp   = err_q ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_holy_clint_mh.sv
// Directed bench for holy_clint_mh (2 harts, TICK_DIV 4, nonzero base).
// Drivers push expected responses; a negedge monitor pops and compares them in order.
module tb_holy_clint_mh;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int          NH   = 2;
  localparam int          TD   = 4;
  localparam logic [1:0]  OKAY = 2'b00;
  localparam logic [1:0]  SERR = 2'b10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NH-1:0] timer_irq;
  logic [NH-1:0] soft_irq;

  axi_lite_if bus ();

  holy_clint_mh #(
    .BASE_ADDR(BASE),
    .NUM_HARTS(NH),
    .TICK_DIV (TD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_axi_lite(bus),
    .timer_irq (timer_irq),
    .soft_irq  (soft_irq)
  );

  always #5 clk = ~clk;

  // Clock edges seen with reset released; mtime should equal cyc / TD until it is written.
  int cyc = 0;
  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: one line per completed bus response.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && bus.rvalid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: got rdata %0h with no read outstanding", bus.rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_wr || bus.rdata !== mon_e.data || bus.rresp !== mon_e.resp) begin
          n_err++;
          $display("FAIL rd_%0h: got rdata %0h rresp %0b (write_expected=%0d) expected rdata %0h rresp %0b",
                   mon_e.addr, bus.rdata, bus.rresp, mon_e.is_wr, mon_e.data, mon_e.resp);
        end else begin
          $display("R  off %05h data %08h resp %0b", mon_e.addr, bus.rdata, bus.rresp);
        end
      end
    end
    if (rst_n && bus.bvalid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got bresp %0b with no write outstanding", bus.bresp);
      end else begin
        mon_e = exp_q.pop_front();
        if (!mon_e.is_wr || bus.bresp !== mon_e.resp) begin
          n_err++;
          $display("FAIL wr_%0h: got bresp %0b (write_expected=%0d) expected bresp %0b",
                   mon_e.addr, bus.bresp, mon_e.is_wr, mon_e.resp);
        end else begin
          $display("W  off %05h resp %0b", mon_e.addr, bus.bresp);
        end
      end
    end
  end

  // All driver tasks are entered just after a rising edge and return just after one.
  task automatic do_read(input logic [31:0] off, input logic [31:0] d, input logic [1:0] r);
    int n = 0;
    bus.araddr  = BASE + off;
    bus.arvalid = 1'b1;
    @(negedge clk);
    while (!bus.arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.arready) chk("ar_timeout", 64'(off), 64'hDEAD);
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
    exp_q.push_back('{is_wr: 1'b0, addr: off, data: d, resp: r});
  endtask

  task automatic w_phase(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] r);
    int n = 0;
    bus.wdata  = d;
    bus.wstrb  = s;
    bus.wvalid = 1'b1;
    @(negedge clk);
    while (!bus.wready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.wready) chk("w_timeout", 64'(off), 64'hDEAD);
    @(posedge clk);
    #1;
    bus.wvalid = 1'b0;
    exp_q.push_back('{is_wr: 1'b1, addr: off, data: 32'h0, resp: r});
  endtask

  task automatic do_write(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] r);
    int n = 0;
    bus.awaddr  = BASE + off;
    bus.awvalid = 1'b1;
    @(negedge clk);
    while (!bus.awready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.awready) chk("aw_timeout", 64'(off), 64'hDEAD);
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
    w_phase(off, d, s, r);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'h0);
  endtask

  initial begin
    int n;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1; bus.bready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valids", {61'h0, bus.rvalid, bus.bvalid, bus.wready}, 64'h0);
    chk("reset_irqs", {60'h0, timer_irq, soft_irq}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // AR handshake on the 9th released edge: mtime = 9/4 = 2.
    n = 0;
    while (cyc != 8 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("sync_cycle8", 64'(cyc), 64'd8);
    do_read(32'hBFF8, 32'h2, OKAY);
    chk("irq_after_reset", 64'(timer_irq), 64'h0);

    // Hart 1 compare at 0x10: fires on the 64th released edge.
    do_write(32'h4008, 32'h10, 4'hF, OKAY);
    do_write(32'h400C, 32'h0, 4'hF, OKAY);
    drain();
    chk("irq_before_match", 64'(timer_irq), 64'h0);
    n = 0;
    while (!timer_irq[1] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("irq1_rise_cycle", 64'(cyc), 64'd64);
    chk("irq_at_match", 64'(timer_irq), 64'b10);

    // Software interrupt: only bit 0 of MSIP is stored.
    do_write(32'h0004, 32'hFFFF_FFFF, 4'hF, OKAY);
    drain();
    chk("soft_set", 64'(soft_irq), 64'b10);
    do_read(32'h0004, 32'h1, OKAY);
    do_write(32'h0004, 32'h0, 4'hF, OKAY);
    drain();
    chk("soft_clear", 64'(soft_irq), 64'b00);
    do_write(32'h0000, 32'h1, 4'h0, OKAY);
    do_read(32'h0000, 32'h0, OKAY);

    // Byte strobes.
    do_write(32'h4000, 32'hAABB_CCDD, 4'b0010, OKAY);
    do_read(32'h4000, 32'hFFFF_CCFF, OKAY);
    do_read(32'h4004, 32'hFFFF_FFFF, OKAY);

    // Unmapped accesses.
    do_read(32'h0003, 32'hFFFF_FFFF, SERR);
    do_read(32'h0008, 32'hFFFF_FFFF, SERR);
    do_write(32'h4010, 32'h1234_5678, 4'hF, SERR);
    do_read(32'h4010, 32'hFFFF_FFFF, SERR);
    do_read(32'h4008, 32'h10, OKAY);
    do_read(32'h400C, 32'h0, OKAY);
    drain();

    // Simultaneous AR and AW: read first, AW only after the R handshake.
    bus.araddr  = BASE + 32'h4008;
    bus.arvalid = 1'b1;
    bus.awaddr  = BASE + 32'h0000;
    bus.awvalid = 1'b1;
    @(negedge clk);
    chk("contend_ar_aw_ready", {62'h0, bus.arready, bus.awready}, 64'b10);
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
    exp_q.push_back('{is_wr: 1'b0, addr: 32'h4008, data: 32'h10, resp: OKAY});
    @(negedge clk);
    n = 0;
    while (!bus.awready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("contend_aw_after_r", {63'h0, bus.awready}, 64'h1);
    chk("contend_r_done", 64'(exp_q.size()), 64'h0);
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
    w_phase(32'h0000, 32'h1, 4'hF, OKAY);
    drain();
    chk("contend_soft", 64'(soft_irq), 64'b01);

    // mtime write and 64-bit wrap; hart 0 compare restored to all ones.
    do_write(32'h4000, 32'hFFFF_FFFF, 4'hF, OKAY);
    do_write(32'hBFFC, 32'hFFFF_FFFF, 4'hF, OKAY);
    do_write(32'hBFF8, 32'hFFFF_FFFE, 4'hF, OKAY);
    chk("irq_before_wrap", 64'(timer_irq), 64'b10);
    n = 0;
    while (!timer_irq[0] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("irq_at_max", 64'(timer_irq), 64'b11);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (timer_irq[0] && n < 20);
    chk("wrap_tick_cycles", 64'(n), 64'd4);
    chk("irq_after_wrap", 64'(timer_irq), 64'b00);
    drain();
    do_read(32'hBFFC, 32'h0, OKAY);
    drain();

    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

endmodule
